// File: rtl/ccc_clken_divider.sv
// ccc_clken_divider: NUM_CH independently programmable clock-enable channels on
// the PLL fabric clock. Each channel divides by D+1 with a start offset P, takes
// run-time reconfiguration at its period boundary, and is gated by a
// synchronised, debounced PLL lock. A sticky flag records lock loss while ready.
module ccc_clken_divider #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 7,
  parameter int LOCK_STABLE = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LC_W = $clog2(LOCK_STABLE + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PLL_LOCK,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic [DIV_W-1:0]  CFG_PHASE,
  input  logic              CFG_EN,
  input  logic              LOCK_LOST_CLR,
  output logic [NUM_CH-1:0] CLKEN,
  output logic [NUM_CH-1:0] CH_ACTIVE,
  output logic [NUM_CH-1:0] CFG_ACK,
  output logic              READY,
  output logic              LOCK_LOST
);

  // Lock path state.
  logic            lock_s1;
  logic            lock_s2;
  logic [LC_W-1:0] lock_cnt;
  logic            ready_nxt;

  // Live per-channel configuration and counter.
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q;

  // Shadow configuration waiting for a safe point to be applied.
  logic [DIV_W-1:0] sdiv_q   [NUM_CH];
  logic [DIV_W-1:0] sphase_q [NUM_CH];
  logic [NUM_CH-1:0] sen_q;
  logic [NUM_CH-1:0] pend_q;

  // Per-channel decisions for the coming edge.
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] en_nxt;
  logic [NUM_CH-1:0] act_nxt;
  logic [NUM_CH-1:0] at_end;
  logic [DIV_W-1:0]  load_val [NUM_CH];

  // READY for the next cycle: synchronised lock still high and stable long enough.
  always_comb begin
    ready_nxt = lock_s2 && (lock_cnt == LC_W'(LOCK_STABLE));
  end

  // Lock synchroniser, debounce counter, READY and sticky LOCK_LOST.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register in
    // this block samples the pre-edge values, exactly like the flops it models.
    if (RST) begin
      lock_s1   <= 1'b0;
      lock_s2   <= 1'b0;
      lock_cnt  <= '0;
      READY     <= 1'b0;
      LOCK_LOST <= 1'b0;
    end else begin
      lock_s1 <= PLL_LOCK;
      lock_s2 <= lock_s1;
      if (!lock_s2) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LC_W'(LOCK_STABLE)) begin
        lock_cnt <= lock_cnt + LC_W'(1);
      end
      READY <= ready_nxt;
      // A drop while READY sets the flag; a coincident clear loses to the set.
      if (!lock_s2 && READY) begin
        LOCK_LOST <= 1'b1;
      end else if (LOCK_LOST_CLR) begin
        LOCK_LOST <= 1'b0;
      end
    end
  end

  // Channel status and pulse decode, from registers only.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      CH_ACTIVE[i] = READY && en_q[i];
      at_end[i]    = (cnt_q[i] == div_q[i]);
      CLKEN[i]     = CH_ACTIVE[i] && at_end[i];
    end
  end

  // Write decode, apply decision and the counter start value on activation.
  always_comb begin
    // NOTE: every output of this block gets a value on every pass, so no latch
    // can be inferred regardless of which branches are taken.
    wr_hit  = '0;
    apply   = '0;
    en_nxt  = '0;
    act_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel numbers never match and are silently dropped.
      wr_hit[i]  = CFG_WE && (int'(CFG_CH) == i);
      // Inactive channels take config at once; active ones only at the pulse.
      apply[i]   = pend_q[i] && (!CH_ACTIVE[i] || at_end[i]);
      en_nxt[i]  = apply[i] ? sen_q[i] : en_q[i];
      act_nxt[i] = ready_nxt && en_nxt[i];
      // Phase beyond the divide value is clamped so the first period is never long.
      if (apply[i]) begin
        load_val[i] = (sphase_q[i] < sdiv_q[i]) ? sphase_q[i] : sdiv_q[i];
      end else begin
        load_val[i] = (phase_q[i] < div_q[i]) ? phase_q[i] : div_q[i];
      end
    end
  end

  // Per-channel live/shadow registers, counters and apply acknowledge.
  always_ff @(posedge CLK) begin
    // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset
    // along with everything else and a reset discards any pending write.
    if (RST) begin
      en_q    <= '0;
      sen_q   <= '0;
      pend_q  <= '0;
      CFG_ACK <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= '0;
        phase_q[i]  <= '0;
        cnt_q[i]    <= '0;
        sdiv_q[i]   <= '0;
        sphase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        CFG_ACK[i] <= apply[i];

        if (apply[i]) begin
          div_q[i]   <= sdiv_q[i];
          phase_q[i] <= sphase_q[i];
          en_q[i]    <= sen_q[i];
          pend_q[i]  <= 1'b0;
        end

        // A write in the same cycle as an apply stays pending for a later apply.
        if (wr_hit[i]) begin
          sdiv_q[i]   <= CFG_DIV;
          sphase_q[i] <= CFG_PHASE;
          sen_q[i]    <= CFG_EN;
          pend_q[i]   <= 1'b1;
        end

        // Counters start at the phase offset on activation, wrap at the period
        // end while running, and hold whenever the channel is inactive.
        if (act_nxt[i] && !CH_ACTIVE[i]) begin
          cnt_q[i] <= load_val[i];
        end else if (act_nxt[i]) begin
          if (apply[i] || at_end[i]) begin
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/ccc_clken_divider.md
# ccc_clken_divider

Parametrised fabric clock-enable generator on the PLL fabric clock (OUTn_FABCLK_0). It provides NUM_CH independently programmable, phase-offset clock-enable channels with run-time reconfiguration. The channels are gated by a synchronised, debounced PLL lock. It adds behaviour the fixed-divider CCC lacks: runtime divide/phase/enable changes applied glitch-free at period boundaries, and lock-loss detection with a sticky flag.

## Interface
- NUM_CH, 4, number of clock-enable channels (1..16)
- DIV_W, 7, width of divide and phase fields
- LOCK_STABLE, 16, consecutive synchronised-lock cycles required before READY (>=1)
- CLK  in  1  fabric clock; sole clock
- RST  in  1  reset, synchronous, active-high
- PLL_LOCK  in  1  PLL lock, asynchronous to CLK
- CFG_WE  in  1  config write strobe, one cycle
- CFG_CH  in  max(1,clog2(NUM_CH))  target channel
- CFG_DIV  in  DIV_W  divide value D; period = D+1 cycles
- CFG_PHASE  in  DIV_W  start offset P
- CFG_EN  in  1  channel enable
- LOCK_LOST_CLR  in  1  clears LOCK_LOST
- CLKEN  out  NUM_CH  per-channel enable pulses
- CH_ACTIVE  out  NUM_CH  channel enabled and READY
- CFG_ACK  out  NUM_CH  one-cycle pulse when pending config applied to channel
- READY  out  1  lock stable
- LOCK_LOST  out  1  sticky: lock dropped while READY

## Operation
- Lock path: 2-flop synchroniser on PLL_LOCK, then saturating counter of consecutive high samples. READY sets when the count reaches LOCK_STABLE. A low synchronised sample clears the counter and READY on the next edge. If READY was 1, it also sets LOCK_LOST. LOCK_LOST_CLR clears it; simultaneous set wins.
- Per channel: live regs div, en, cnt (DIV_W); shadow regs sdiv, sphase, sen, pend.
- CFG_WE with CFG_CH < NUM_CH: shadow <= CFG_*, pend <= 1. CFG_CH >= NUM_CH: ignored, no ACK. Repeated writes while pending overwrite the shadow; one ACK results.
- Apply condition: pend & (!CH_ACTIVE | cnt==div), i.e. immediately if inactive, else at the period-boundary (pulse) cycle. On apply: div <= sdiv, en <= sen, pend <= 0, CFG_ACK[i] pulses next cycle.
- Counter load: when a channel becomes active (en 0->1 with READY=1, or READY 0->1 with en=1), cnt <= min(sphase-latched phase, div). The phase register is live, loaded from sphase on apply. Otherwise, when active: cnt <= (cnt==div) ? 0 : cnt+1. Apply at a boundary while staying enabled: cnt <= 0; phase is not reapplied.
- CLKEN[i] = CH_ACTIVE[i] & (cnt==div), decoded from registers only (no input-to-output path). D=0 gives CLKEN constantly high.
- CH_ACTIVE[i] = READY & en[i].
- Disable applied at a boundary: the final pulse of that period is emitted, then none.
- Lock loss mid-run: READY falls, all CLKEN low from the same edge, counters held. Pending configs apply immediately (channels inactive) with ACK.
- Write in the same cycle as an apply on the same channel: the apply uses the pre-write shadow; the new write stays pending and yields a second ACK later.

## Timing
- Reset values: CLKEN=0, CH_ACTIVE=0, CFG_ACK=0, READY=0, LOCK_LOST=0, all div/phase/cnt=0, en=0, pend=0, lock counter=0.
- READY rises LOCK_STABLE+2 edges after the first edge sampling PLL_LOCK=1. It falls 3 edges after PLL_LOCK falls (2 sync + 1).
- Inactive channel config: write edge k, apply edge k+1, CFG_ACK high in cycle after k+1.
- First pulse after activation: D-P cycles after the first active cycle (P clamped to D). Thereafter, every D+1 cycles.
- RST mid-operation: all state returns to reset values on that edge; pending writes are discarded.

## Test plan
- Lock debounce: PLL_LOCK high, with a one-cycle low glitch at cycle 10, LOCK_STABLE=16 -> READY high exactly 18 edges after the glitch ends; LOCK_LOST stays 0.
- Divide/phase: ch0 D=3 P=0, ch1 D=3 P=2, after READY -> ch0 pulses at active cycles 3,7,11; ch1 at 1,5,9; D=0 on ch2 -> CLKEN[2] continuously high.
- Glitch-free reconfig: ch0 running D=4, write D=1 mid-period -> current 5-cycle period completes, ACK on the boundary, then a period of 2; no pulse gap or double pulse.
- Disable at boundary: ch1 D=5 active, write EN=0 -> one final pulse, ACK, CH_ACTIVE[1]=0, no further pulses.
- Lock loss: drop PLL_LOCK with 4 channels active -> all CLKEN low within 3 edges, LOCK_LOST=1 until LOCK_LOST_CLR. Relock -> channels restart with their phase offsets.
- Edge cases: CFG_CH=NUM_CH -> no ACK, no state change. Write coincident with a boundary apply -> two ACKs, the final live config equals the second write. RST asserted mid-pulse -> all outputs 0 next cycle.
